instr_fetch_unit: RTL
=====================

Name: instr_fetch_unit

Overview:
- Upstream neighbour of the single-cycle controller: owns the PC, fetches 32-bit MIPS words from instruction memory over a req/ack handshake and holds each word in an instruction register.
- Presents Op/func to the controller and takes the controller's PCSrc back to select PC+4 or the branch target.
- Sequential core: 4-state FSM, PC register, wait-timeout counter.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- MAX_WAIT, 8, number of FETCH cycles without IMem_Ack before a fetch error (1..255).

Ports:
- Clk  input  1  system clock; all state updates on the rising edge.
- Rst  input  1  synchronous, active-low reset, sampled on rising Clk.
- IMem_Req  output  1  fetch request to instruction memory.
- IMem_Addr  output  32  byte address of the fetch; equals PC.
- IMem_Data  input  32  instruction word; valid when IMem_Ack=1.
- IMem_Ack  input  1  memory has returned IMem_Data this cycle.
- PCSrc  input  1  from controller: 1 = take branch for the instruction currently held.
- Instr_Ready  input  1  downstream datapath consumes the held instruction this cycle.
- Instr  output  32  instruction register.
- Instr_Valid  output  1  Instr holds an unconsumed instruction.
- Op  output  6  Instr[31:26].
- func  output  6  Instr[5:0].
- PC_Out  output  32  address of the held instruction.
- Fetch_Err  output  1  sticky fetch-timeout flag.

Behaviour:
- Reset (Rst=0 at posedge): PC=RESET_PC, state=IDLE, wait counter=0, Instr=0, Instr_Valid=0, IMem_Req=0, Fetch_Err=0. Reset overrides every other input, including mid-handshake.
- Combinational outputs: IMem_Addr=PC and PC_Out=PC.
- State IDLE: lasts exactly 1 cycle after reset release, then FETCH.
- State FETCH:
  - IMem_Req=1.
  - If IMem_Ack=1: Instr<=IMem_Data, Instr_Valid<=1, wait counter<=0, go to ISSUE.
  - Otherwise the wait counter increments. When it reaches MAX_WAIT with no ack, go to ERR, Fetch_Err<=1 and IMem_Req drops.
- State ISSUE:
  - IMem_Req=0 and Instr_Valid=1.
  - If Instr_Ready=0: Instr and PC are held.
  - If Instr_Ready=1:
    - PC <= PCSrc ? PC+4+({{14{Instr[15]}},Instr[15:0],2'b00}) : PC+4.
    - Instr_Valid<=0, go to FETCH.
- State ERR: IMem_Req=0, Instr_Valid=0, Fetch_Err=1. Only reset exits ERR.
- Arithmetic: all PC math is 32-bit modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0. The branch offset is word-shifted, so PC[1:0] stays 00.
- PCSrc is sampled only on the Instr_Ready cycle in ISSUE and is ignored in all other states.
- IMem_Ack is ignored outside FETCH; a late ack in ISSUE or ERR changes nothing.
- Ack on the MAX_WAIT-th cycle: the ack wins and no error is raised.
- Throughput: minimum 2 cycles per instruction (FETCH with same-cycle ack, then ISSUE with Instr_Ready=1).
- Op/func reset to 0 because Instr resets to 0 (decodes as SLL $0, a NOP).

Optional Feature:
- Macro IF_PERF_CNT_EN.
- Defined: adds output Stall_Cnt[31:0], reset to 0. It increments by 1 on every cycle spent in FETCH with IMem_Ack=0, or in ISSUE with Instr_Ready=0, and saturates at 32'hFFFF_FFFF.
- Not defined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Reset then ack on the first FETCH cycle with IMem_Data=32'h2008_0005; hold Instr_Ready=0 → IMem_Addr=0 while requesting; then Instr=32'h2008_0005, Op=6'h08, Instr_Valid=1, PC_Out=0 held.
- Sequential fetch, Instr_Ready=1 and PCSrc=0 → IMem_Addr sequence 0,4,8,12, one instruction every 2 cycles.
- Branch taken: PC=0x10, Instr=32'h1509_FFFC (bne, imm=-4), PCSrc=1 with Instr_Ready=1 → next IMem_Addr = 0x14-16 = 0x04.
- Wrap: RESET_PC=32'hFFFF_FFFC, one sequential fetch → next IMem_Addr=0.
- Timeout: MAX_WAIT=8, IMem_Ack held 0 → Fetch_Err=1 after 8 FETCH cycles and IMem_Req=0. A later ack changes nothing, and Rst=0 for one edge clears Fetch_Err with PC=RESET_PC.
- Reset mid-handshake: Rst=0 during FETCH wait and ISSUE stall → all outputs take reset values on the next edge. With IF_PERF_CNT_EN, 3 ack-wait cycles plus 2 ready-stall cycles give Stall_Cnt=5.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches words over a req/ack handshake and holds them
// for the controller. Optional stall counter enabled by defining IF_PERF_CNT_EN.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic        Clk,
    input  logic        Rst,
    output logic        IMem_Req,
    output logic [31:0] IMem_Addr,
    input  logic [31:0] IMem_Data,
    input  logic        IMem_Ack,
    input  logic        PCSrc,
    input  logic        Instr_Ready,
    output logic [31:0] Instr,
    output logic        Instr_Valid,
    output logic [5:0]  Op,
    output logic [5:0]  func,
    output logic [31:0] PC_Out,
    output logic        Fetch_Err
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] Stall_Cnt
`endif
);

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StIssue,
        StErr
    } state_e;

    localparam logic [7:0] MaxWait = 8'(MAX_WAIT);

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic [7:0]  wait_q;
    logic        req_q;
    logic        valid_q;
    logic        err_q;

    logic [7:0]  wait_inc;
    logic [31:0] pc_plus4;
    logic [31:0] br_off;
    logic [31:0] pc_next;

    assign wait_inc = wait_q + 8'd1;
    assign pc_plus4 = pc_q + 32'd4;
    // Word-shifted, sign-extended immediate keeps PC[1:0] at 00.
    assign br_off   = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    assign pc_next  = PCSrc ? (pc_plus4 + br_off) : pc_plus4;

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_q <= StIdle;
            pc_q    <= RESET_PC;
            instr_q <= 32'd0;
            wait_q  <= 8'd0;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    state_q <= StFetch;
                    req_q   <= 1'b1;
                end
                StFetch: begin
                    if (IMem_Ack) begin
                        instr_q <= IMem_Data;
                        valid_q <= 1'b1;
                        wait_q  <= 8'd0;
                        req_q   <= 1'b0;
                        state_q <= StIssue;
                    end else if (wait_inc == MaxWait) begin
                        wait_q  <= wait_inc;
                        req_q   <= 1'b0;
                        err_q   <= 1'b1;
                        state_q <= StErr;
                    end else begin
                        wait_q <= wait_inc;
                    end
                end
                StIssue: begin
                    if (Instr_Ready) begin
                        pc_q    <= pc_next;
                        valid_q <= 1'b0;
                        req_q   <= 1'b1;
                        state_q <= StFetch;
                    end
                end
                StErr: begin
                    // Sticky until reset.
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                    err_q   <= 1'b1;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] stall_q;
    logic        stall_evt;

    assign stall_evt = ((state_q == StFetch) && !IMem_Ack) ||
                       ((state_q == StIssue) && !Instr_Ready);

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            stall_q <= 32'd0;
        end else if (stall_evt && (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign Stall_Cnt = stall_q;
`endif

    assign IMem_Req    = req_q;
    assign IMem_Addr   = pc_q;
    assign PC_Out      = pc_q;
    assign Instr       = instr_q;
    assign Instr_Valid = valid_q;
    assign Op          = instr_q[31:26];
    assign func        = instr_q[5:0];
    assign Fetch_Err   = err_q;

endmodule
